// File: rtl/key_pkg.sv
// Shared definitions for the keyboard conditioning path: arrow keycodes,
// the arrow filter helper, and the press/auto-repeat FSM state encoding.
package key_pkg;

  localparam logic [7:0] KEY_RIGHT = 8'd79;
  localparam logic [7:0] KEY_LEFT  = 8'd80;
  localparam logic [7:0] KEY_DOWN  = 8'd81;
  localparam logic [7:0] KEY_UP    = 8'd82;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

  // True for the four codes the ball motion stage understands.
  function automatic logic is_arrow(input logic [7:0] code);
    return (code == KEY_RIGHT) || (code == KEY_LEFT) ||
           (code == KEY_DOWN)  || (code == KEY_UP);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Frame-based debouncer for the filtered arrow code. A code is accepted once
// it has been seen on DEBOUNCE_FRAMES consecutive frames; release (code 0)
// goes through the same path. accepted_next exposes the value accepted will
// take on the coming edge so the top level can suppress a pulse that would
// land on the same edge as a release.
module key_debounce #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int CNT_W           = 6
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic [7:0]       code_in,
  output logic [7:0]       accepted,
  output logic [7:0]       accepted_next,
  output logic             key_valid
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [7:0]       candidate;
  logic [CNT_W-1:0] stable_cnt;
  logic             saturated;

  assign saturated     = (stable_cnt == STABLE_LAST);
  assign accepted_next = saturated ? candidate : accepted;

  // Track how long the candidate has been stable and promote it once saturated.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      candidate  <= 8'd0;
      stable_cnt <= '0;
      accepted   <= 8'd0;
      key_valid  <= 1'b0;
    end else begin
      if (code_in != candidate) begin
        candidate  <= code_in;
        stable_cnt <= '0;
      end else if (!saturated) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
      accepted  <= accepted_next;
      key_valid <= (accepted_next != 8'd0);
    end
  end

endmodule

// File: rtl/key_repeat_gen.sv
// Conditions the raw USB keycode for the ball motion stage: arrow filter,
// frame debounce, then either a first-step pulse plus auto-repeat pulses
// (KEY_REPEAT_EN defined) or the accepted key on every frame (KEY_REPEAT_EN
// undefined, continuous motion).
module key_repeat_gen
  import key_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY    = 15,
  parameter int REPEAT_PERIOD   = 4,
  parameter int CNT_W           = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  output logic [7:0] keycode_out,
  output logic       key_valid,
  output logic [7:0] press_cnt
);

  logic [7:0] filt_code;
  logic [7:0] accepted;
  logic [7:0] acc_next;
  logic [7:0] prev_acc;
  logic       new_press;

  // Register the raw keycode, mapping anything that is not an arrow to 0.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      filt_code <= 8'd0;
    end else begin
      filt_code <= is_arrow(keycode_in) ? keycode_in : 8'd0;
    end
  end

  key_debounce #(
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .code_in       (filt_code),
    .accepted      (accepted),
    .accepted_next (acc_next),
    .key_valid     (key_valid)
  );

  // A new press is a nonzero accepted key differing from last frame's, and
  // not being released on this very edge.
  assign new_press = (accepted != 8'd0) && (accepted != prev_acc) &&
                     (acc_next != 8'd0);

`ifdef KEY_REPEAT_EN

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  key_state_e       state, state_next;
  logic [CNT_W-1:0] rep_cnt, rep_cnt_next;
  logic             pulse;

  // FSM state and repeat counter registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      rep_cnt <= '0;
    end else begin
      state   <= state_next;
      rep_cnt <= rep_cnt_next;
    end
  end

  // Decide whether this edge emits a pulse and where the FSM goes next.
  always_comb begin
    state_next   = state;
    rep_cnt_next = rep_cnt;
    pulse        = 1'b0;
    if (acc_next == 8'd0) begin
      state_next   = IDLE;
      rep_cnt_next = '0;
    end else if (new_press) begin
      pulse        = 1'b1;
      rep_cnt_next = '0;
      state_next   = DELAY;
    end else begin
      unique case (state)
        IDLE: begin
          rep_cnt_next = '0;
        end
        DELAY: begin
          if (rep_cnt == DELAY_LAST) begin
            pulse        = 1'b1;
            rep_cnt_next = '0;
            state_next   = REPEAT;
          end else begin
            rep_cnt_next = rep_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (rep_cnt == PERIOD_LAST) begin
            pulse        = 1'b1;
            rep_cnt_next = '0;
          end else begin
            rep_cnt_next = rep_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end
      endcase
    end
  end

  // Register the pulse output, the press counter and last frame's key.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      keycode_out <= 8'd0;
      press_cnt   <= 8'd0;
      prev_acc    <= 8'd0;
    end else begin
      keycode_out <= pulse ? accepted : 8'd0;
      if (new_press) begin
        press_cnt <= press_cnt + 8'd1;
      end
      prev_acc <= accepted;
    end
  end

`else

  // Continuous mode: forward the accepted key every frame and count presses.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      keycode_out <= 8'd0;
      press_cnt   <= 8'd0;
      prev_acc    <= 8'd0;
    end else begin
      keycode_out <= accepted;
      if (new_press) begin
        press_cnt <= press_cnt + 8'd1;
      end
      prev_acc <= accepted;
    end
  end

`endif

endmodule

// File: tb/tb_key_repeat_gen.sv
// Directed bench for key_repeat_gen with default parameters. Expected values
// follow the pulse/repeat behaviour when KEY_REPEAT_EN is defined and the
// continuous per-frame output otherwise.
module tb_key_repeat_gen;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode_in;
  logic [7:0] keycode_out;
  logic       key_valid;
  logic [7:0] press_cnt;

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  key_repeat_gen dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode_in  (keycode_in),
    .keycode_out (keycode_out),
    .key_valid   (key_valid),
    .press_cnt   (press_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one frame of keycode and return just after the sampling edge.
  task automatic applyStimulus(input logic [7:0] code);
    keycode_in = code;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic resetDut();
    Reset      = 1'b1;
    keycode_in = 8'd0;
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_kc;
    Reset      = 1'b1;
    keycode_in = 8'd0;
    repeat (2) @(posedge frame_clk);
    #1;
    checkOutput("reset_keycode_out", 32'(keycode_out), 32'd0);
    checkOutput("reset_key_valid", 32'(key_valid), 32'd0);
    checkOutput("reset_press_cnt", 32'(press_cnt), 32'd0);
    Reset = 1'b0;

    // Hold LEFT (80) for 40 frames, edges 0..39.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(8'd80);
`ifdef KEY_REPEAT_EN
      exp_kc = (n == 4 || (n >= 19 && (n - 19) % 4 == 0)) ? 8'd80 : 8'd0;
`else
      exp_kc = (n >= 4) ? 8'd80 : 8'd0;
`endif
      checkOutput($sformatf("hold80_kc_e%0d", n), 32'(keycode_out), 32'(exp_kc));
      checkOutput($sformatf("hold80_kv_e%0d", n), 32'(key_valid), (n >= 3) ? 32'd1 : 32'd0);
    end
    checkOutput("hold80_press_cnt", 32'(press_cnt), 32'd1);

    // Release: edge 43 would have been a repeat pulse but coincides with release.
    for (int m = 0; m < 10; m++) begin
      applyStimulus(8'd0);
`ifdef KEY_REPEAT_EN
      exp_kc = 8'd0;
`else
      exp_kc = (m <= 3) ? 8'd80 : 8'd0;
`endif
      checkOutput($sformatf("rel80_kc_m%0d", m), 32'(keycode_out), 32'(exp_kc));
      checkOutput($sformatf("rel80_kv_m%0d", m), 32'(key_valid), (m < 3) ? 32'd1 : 32'd0);
    end
    checkOutput("rel80_press_cnt", 32'(press_cnt), 32'd1);

    // One-frame glitch of UP (82).
    resetDut();
    applyStimulus(8'd82);
    checkOutput("glitch_kc_e0", 32'(keycode_out), 32'd0);
    for (int n = 1; n < 10; n++) begin
      applyStimulus(8'd0);
      checkOutput($sformatf("glitch_kc_e%0d", n), 32'(keycode_out), 32'd0);
      checkOutput($sformatf("glitch_kv_e%0d", n), 32'(key_valid), 32'd0);
    end
    checkOutput("glitch_press_cnt", 32'(press_cnt), 32'd0);

    // RIGHT (79) then DOWN (81) switched in at edge 8, during DELAY.
    resetDut();
    for (int n = 0; n < 8; n++) begin
      applyStimulus(8'd79);
`ifdef KEY_REPEAT_EN
      exp_kc = (n == 4) ? 8'd79 : 8'd0;
`else
      exp_kc = (n >= 4) ? 8'd79 : 8'd0;
`endif
      checkOutput($sformatf("sw79_kc_e%0d", n), 32'(keycode_out), 32'(exp_kc));
      checkOutput($sformatf("sw79_kv_e%0d", n), 32'(key_valid), (n >= 3) ? 32'd1 : 32'd0);
    end
    for (int n = 8; n < 28; n++) begin
      applyStimulus(8'd81);
`ifdef KEY_REPEAT_EN
      exp_kc = (n == 12 || n == 27) ? 8'd81 : 8'd0;
`else
      exp_kc = (n < 12) ? 8'd79 : 8'd81;
`endif
      checkOutput($sformatf("sw81_kc_e%0d", n), 32'(keycode_out), 32'(exp_kc));
      checkOutput($sformatf("sw81_kv_e%0d", n), 32'(key_valid), 32'd1);
    end
    checkOutput("switch_press_cnt", 32'(press_cnt), 32'd2);

    // Non-arrow code 4 is filtered out entirely.
    resetDut();
    for (int n = 0; n < 20; n++) begin
      applyStimulus(8'd4);
      checkOutput($sformatf("code4_kc_e%0d", n), 32'(keycode_out), 32'd0);
      checkOutput($sformatf("code4_kv_e%0d", n), 32'(key_valid), 32'd0);
    end
    checkOutput("code4_press_cnt", 32'(press_cnt), 32'd0);

    // Asynchronous reset while auto-repeating.
    resetDut();
    for (int n = 0; n < 25; n++) begin
      applyStimulus(8'd80);
    end
    checkOutput("midrst_pre_kv", 32'(key_valid), 32'd1);
    checkOutput("midrst_pre_press", 32'(press_cnt), 32'd1);
    #3;
    Reset      = 1'b1;
    keycode_in = 8'd0;
    #1;
    checkOutput("midrst_kc", 32'(keycode_out), 32'd0);
    checkOutput("midrst_kv", 32'(key_valid), 32'd0);
    checkOutput("midrst_press", 32'(press_cnt), 32'd0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      applyStimulus(8'd0);
      checkOutput($sformatf("postrst_kc_e%0d", n), 32'(keycode_out), 32'd0);
    end

    // 256 separate presses wrap the press counter.
    resetDut();
    for (int p = 0; p < 256; p++) begin
      repeat (4) applyStimulus(8'd80);
      repeat (4) applyStimulus(8'd0);
      if (p == 0) checkOutput("wrap_press_1", 32'(press_cnt), 32'd1);
      if (p == 254) checkOutput("wrap_press_255", 32'(press_cnt), 32'd255);
    end
    checkOutput("wrap_press_0", 32'(press_cnt), 32'd0);
    checkOutput("wrap_kv", 32'(key_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
